// File: rtl/regdest_pkg.sv
// Shared types and constants for the register-file write-port scheduler.
// Build option: REGDEST_RR_EN selects round-robin arbitration (default fixed priority).
package regdest_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    localparam logic [2:0] SEL_RT  = 3'b000;
    localparam logic [2:0] SEL_RD  = 3'b001;
    localparam logic [2:0] SEL_SP  = 3'b010;
    localparam logic [2:0] SEL_R30 = 3'b011;
    localparam logic [2:0] SEL_RA  = 3'b100;

    // Hold counter width; WRITE_CYCLES tops out at 4, so a load of 3 fits.
    localparam int HOLD_W = 2;

    function automatic logic is_legal_sel(input logic [2:0] sel);
        return (sel <= SEL_RA);
    endfunction

endpackage

// File: rtl/regdest_arbiter.sv
// Combinational arbiter: request vector (plus rotating pointer) -> one-hot winner and index.
// Build option: REGDEST_RR_EN selects round-robin; otherwise lowest index wins.
module regdest_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
`ifdef REGDEST_RR_EN
    input  logic [IDX_W-1:0] ptr,
`endif
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx
);

    always_comb begin : arb
        logic found;
`ifdef REGDEST_RR_EN
        int   j;
`endif
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
`ifdef REGDEST_RR_EN
        j     = 0;
        // Walk the ring once starting at the pointer; first requester found wins.
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!found && req[IDX_W'(j)]) begin
                found = 1'b1;
                idx   = IDX_W'(j);
            end
        end
`else
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[IDX_W'(i)]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
`endif
        if (found) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/regdest_write_sched.sv
// Single register-file write port scheduler: arbitrates writeback sources, holds reg_write, returns grant.
// Build option: REGDEST_RR_EN enables round-robin arbitration with a rotating pointer.
module regdest_write_sched
    import regdest_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int DATA_W       = 32,
    parameter int WRITE_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    stall,
    input  logic [N_REQ-1:0]        req,
    input  logic [3*N_REQ-1:0]      req_sel,
    input  logic [DATA_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]        grant,
    output logic [2:0]              seletor_regdest,
    output logic                    reg_write,
    output logic [DATA_W-1:0]       write_data,
    output logic                    sel_err,
    output logic                    busy
);

    localparam int IDX_W = $clog2(N_REQ);

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   cnt_q, cnt_d;
    logic [N_REQ-1:0]    win_oh_q, win_oh_d;
    logic [2:0]          sel_q, sel_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                illegal_q, illegal_d;

    logic [N_REQ-1:0]    arb_gnt;
    logic [IDX_W-1:0]    arb_idx;
    logic [2:0]          sel_arr  [N_REQ];
    logic [DATA_W-1:0]   data_arr [N_REQ];

`ifdef REGDEST_RR_EN
    logic [IDX_W-1:0]    win_idx_q, win_idx_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign sel_arr[gi]  = req_sel[3*gi +: 3];
            assign data_arr[gi] = req_data[DATA_W*gi +: DATA_W];
        end
    endgenerate

    regdest_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req (req),
`ifdef REGDEST_RR_EN
        .ptr (ptr_q),
`endif
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        win_oh_d  = win_oh_q;
        sel_d     = sel_q;
        data_d    = data_q;
        illegal_d = illegal_q;
`ifdef REGDEST_RR_EN
        win_idx_d = win_idx_q;
        ptr_d     = ptr_q;
`endif
        grant     = '0;
        reg_write = 1'b0;
        sel_err   = 1'b0;
        busy      = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (!stall && (|arb_gnt)) begin
                    state_d   = WRITE;
                    cnt_d     = HOLD_W'(WRITE_CYCLES - 1);
                    win_oh_d  = arb_gnt;
                    illegal_d = !is_legal_sel(sel_arr[arb_idx]);
                    // An illegal code must never steer the mux to an unintended register.
                    sel_d     = is_legal_sel(sel_arr[arb_idx]) ? sel_arr[arb_idx] : SEL_RT;
                    data_d    = data_arr[arb_idx];
`ifdef REGDEST_RR_EN
                    win_idx_d = arb_idx;
`endif
                end
            end
            WRITE: begin
                reg_write = !illegal_q;
                if (!stall) begin
                    if (cnt_q == '0) begin
                        grant   = win_oh_q;
                        sel_err = illegal_q;
                        state_d = IDLE;
`ifdef REGDEST_RR_EN
                        ptr_d   = (int'(win_idx_q) == N_REQ - 1) ? '0 : win_idx_q + 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            win_oh_q  <= '0;
            sel_q     <= SEL_RT;
            data_q    <= '0;
            illegal_q <= 1'b0;
`ifdef REGDEST_RR_EN
            win_idx_q <= '0;
            ptr_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            win_oh_q  <= win_oh_d;
            sel_q     <= sel_d;
            data_q    <= data_d;
            illegal_q <= illegal_d;
`ifdef REGDEST_RR_EN
            win_idx_q <= win_idx_d;
            ptr_q     <= ptr_d;
`endif
        end
    end

    assign seletor_regdest = sel_q;
    assign write_data      = data_q;

endmodule

// File: tb/tb_regdest_write_sched.sv
// Directed self-checking bench for regdest_write_sched (one 1-cycle and one 3-cycle hold instance).
// Honours REGDEST_RR_EN when choosing expected arbitration order.
module tb_regdest_write_sched;

    logic         clk;
    logic         reset_n;

    logic         stall;
    logic [3:0]   req;
    logic [11:0]  req_sel;
    logic [127:0] req_data;
    logic [3:0]   grant;
    logic [2:0]   seletor_regdest;
    logic         reg_write;
    logic [31:0]  write_data;
    logic         sel_err;
    logic         busy;

    logic         stall3;
    logic [3:0]   req3;
    logic [11:0]  req_sel3;
    logic [127:0] req_data3;
    logic [3:0]   grant3;
    logic [2:0]   seletor_regdest3;
    logic         reg_write3;
    logic [31:0]  write_data3;
    logic         sel_err3;
    logic         busy3;

    int checks   = 0;
    int failures = 0;

`ifdef REGDEST_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    regdest_write_sched #(.N_REQ(4), .DATA_W(32), .WRITE_CYCLES(1)) dut1 (
        .clk             (clk),
        .reset_n         (reset_n),
        .stall           (stall),
        .req             (req),
        .req_sel         (req_sel),
        .req_data        (req_data),
        .grant           (grant),
        .seletor_regdest (seletor_regdest),
        .reg_write       (reg_write),
        .write_data      (write_data),
        .sel_err         (sel_err),
        .busy            (busy)
    );

    regdest_write_sched #(.N_REQ(4), .DATA_W(32), .WRITE_CYCLES(3)) dut3 (
        .clk             (clk),
        .reset_n         (reset_n),
        .stall           (stall3),
        .req             (req3),
        .req_sel         (req_sel3),
        .req_data        (req_data3),
        .grant           (grant3),
        .seletor_regdest (seletor_regdest3),
        .reg_write       (reg_write3),
        .write_data      (write_data3),
        .sel_err         (sel_err3),
        .busy            (busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nx;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] eg;
        int         e;

        // Test 1: reset held with all sources requesting
        reset_n   = 1'b0;
        stall     = 1'b0;
        req       = 4'b1111;
        req_sel   = {3'b001, 3'b001, 3'b001, 3'b001};
        req_data  = {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
        stall3    = 1'b0;
        req3      = 4'b0000;
        req_sel3  = '0;
        req_data3 = '0;
        repeat (3) nx;
        chk("rst_grant", grant, 4'b0000);
        chk("rst_reg_write", reg_write, 1'b0);
        chk("rst_sel_err", sel_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_seletor", seletor_regdest, 3'b000);
        chk("rst_write_data", write_data, 32'h0);
        reset_n = 1'b1;

        // Tests 1/3: all requests held, grant every 2 cycles
        for (int g = 0; g < 5; g++) begin
            e  = RR ? (g % 4) : 0;
            eg = 4'b0001 << e;
            nx;
            chk("rr_grant", grant, eg);
            chk("rr_reg_write", reg_write, 1'b1);
            chk("rr_seletor", seletor_regdest, 3'b001);
            chk("rr_write_data", write_data, 32'h1000_0000 + e);
            nx;
            chk("rr_idle_grant", grant, 4'b0000);
            chk("rr_idle_busy", busy, 1'b0);
            chk("rr_idle_data_hold", write_data, 32'h1000_0000 + e);
        end
        req = 4'b0000;

        // Test 2: single request from source 2, $31 destination
        req_sel  = {3'b001, 3'b100, 3'b000, 3'b010};
        req_data = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111, 32'h0000_0000};
        req      = 4'b0100;
        nx;
        chk("t2_grant", grant, 4'b0100);
        chk("t2_reg_write", reg_write, 1'b1);
        chk("t2_seletor", seletor_regdest, 3'b100);
        chk("t2_write_data", write_data, 32'hDEAD_BEEF);
        chk("t2_sel_err", sel_err, 1'b0);
        req = 4'b0000;
        nx;
        chk("t2_idle_reg_write", reg_write, 1'b0);
        chk("t2_idle_grant", grant, 4'b0000);
        chk("t2_idle_seletor_hold", seletor_regdest, 3'b100);
        chk("t2_idle_data_hold", write_data, 32'hDEAD_BEEF);

        // Test 4: illegal destination code from source 1
        req_sel  = {3'b001, 3'b100, 3'b110, 3'b010};
        req_data = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_0000};
        req      = 4'b0010;
        nx;
        chk("t4_reg_write", reg_write, 1'b0);
        chk("t4_sel_err", sel_err, 1'b1);
        chk("t4_grant", grant, 4'b0010);
        chk("t4_seletor", seletor_regdest, 3'b000);
        chk("t4_busy", busy, 1'b1);
        req = 4'b0000;
        nx;
        chk("t4_idle_sel_err", sel_err, 1'b0);
        chk("t4_idle_grant", grant, 4'b0000);
        chk("t4_idle_seletor_hold", seletor_regdest, 3'b000);

        // Two requesters: fixed priority and the rotated pointer both pick source 0
        req_sel = {3'b001, 3'b100, 3'b011, 3'b010};
        req     = 4'b0011;
        nx;
        chk("pair_grant", grant, 4'b0001);
        chk("pair_seletor", seletor_regdest, 3'b010);
        chk("pair_write_data", write_data, 32'h0000_0000);
        req = 4'b0000;
        nx;
        chk("pair_idle_busy", busy, 1'b0);

        // Stall in IDLE blocks a new grant
        req   = 4'b0100;
        stall = 1'b1;
        nx;
        chk("stall_idle_busy", busy, 1'b0);
        chk("stall_idle_reg_write", reg_write, 1'b0);
        stall = 1'b0;
        nx;
        chk("stall_rel_grant", grant, 4'b0100);
        chk("stall_rel_seletor", seletor_regdest, 3'b100);
        req = 4'b0000;
        nx;
        chk("stall_rel_idle", busy, 1'b0);

        // Test 5: WRITE_CYCLES=3 with a 2-cycle stall mid-write
        req_sel3  = {3'b000, 3'b000, 3'b000, 3'b001};
        req_data3 = {32'h0, 32'h0, 32'h0, 32'h55AA_55AA};
        req3      = 4'b0001;
        nx;
        chk("t5_c1_reg_write", reg_write3, 1'b1);
        chk("t5_c1_grant", grant3, 4'b0000);
        chk("t5_c1_seletor", seletor_regdest3, 3'b001);
        stall3 = 1'b1;
        nx;
        chk("t5_c2_reg_write", reg_write3, 1'b1);
        chk("t5_c2_grant", grant3, 4'b0000);
        nx;
        chk("t5_c3_reg_write", reg_write3, 1'b1);
        chk("t5_c3_grant", grant3, 4'b0000);
        stall3 = 1'b0;
        nx;
        chk("t5_c4_reg_write", reg_write3, 1'b1);
        chk("t5_c4_grant", grant3, 4'b0000);
        nx;
        chk("t5_c5_reg_write", reg_write3, 1'b1);
        chk("t5_c5_grant", grant3, 4'b0001);
        chk("t5_c5_write_data", write_data3, 32'h55AA_55AA);
        req3 = 4'b0000;
        nx;
        chk("t5_end_reg_write", reg_write3, 1'b0);
        chk("t5_end_busy", busy3, 1'b0);

        // Test 6: reset pulled during WRITE, request re-served afterwards
        req_sel3  = {3'b000, 3'b100, 3'b000, 3'b000};
        req_data3 = {32'h0, 32'h0BAD_F00D, 32'h0, 32'h0};
        req3      = 4'b0100;
        nx;
        chk("t6_pre_reg_write", reg_write3, 1'b1);
        chk("t6_pre_busy", busy3, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_reg_write", reg_write3, 1'b0);
        chk("t6_rst_busy", busy3, 1'b0);
        chk("t6_rst_grant", grant3, 4'b0000);
        chk("t6_rst_seletor", seletor_regdest3, 3'b000);
        chk("t6_rst_write_data", write_data3, 32'h0);
        repeat (2) begin
            nx;
            chk("t6_hold_grant", grant3, 4'b0000);
            chk("t6_hold_reg_write", reg_write3, 1'b0);
        end
        reset_n = 1'b1;
        nx;
        chk("t6_re_c1_reg_write", reg_write3, 1'b1);
        chk("t6_re_c1_grant", grant3, 4'b0000);
        chk("t6_re_c1_seletor", seletor_regdest3, 3'b100);
        nx;
        chk("t6_re_c2_grant", grant3, 4'b0000);
        nx;
        chk("t6_re_c3_grant", grant3, 4'b0100);
        chk("t6_re_c3_write_data", write_data3, 32'h0BAD_F00D);
        req3 = 4'b0000;
        nx;
        chk("t6_end_busy", busy3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
